// File: rtl/ex_pkg.sv
// Shared widths, ALU/shifter op codes and the EX/MEM latch layout for the execute stage.
package ex_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 12;
    localparam int REG_W  = 3;

    localparam logic [2:0] ACODE_ADD   = 3'b000;
    localparam logic [2:0] ACODE_ADC   = 3'b001;
    localparam logic [2:0] ACODE_SUB   = 3'b010;
    localparam logic [2:0] ACODE_SBC   = 3'b011;
    localparam logic [2:0] ACODE_AND   = 3'b100;
    localparam logic [2:0] ACODE_OR    = 3'b101;
    localparam logic [2:0] ACODE_XOR   = 3'b110;
    localparam logic [2:0] ACODE_PASSB = 3'b111;

    localparam logic [1:0] SCODE_SHL = 2'b00;
    localparam logic [1:0] SCODE_SHR = 2'b01;
    localparam logic [1:0] SCODE_ROL = 2'b10;
    localparam logic [1:0] SCODE_ROR = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  dest;
        logic [PC_W-1:0]   branch_target;
        logic              mem_read_write;
        logic [1:0]        pc_src;
        logic              mem_or_alu;
        logic              reg_write;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '0;

    // Sign-extend the 8-bit branch offset to PC width.
    function automatic logic [PC_W-1:0] sext_offset(input logic [DATA_W-1:0] off);
        return {{(PC_W-DATA_W){off[DATA_W-1]}}, off};
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU plus barrel shifter; c_valid marks ops that define a new carry.
module alu8
    import ex_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic [2:0]        acode,
    input  logic              is_shift,
    input  logic [1:0]        scode,
    input  logic [2:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              c_valid
);

    logic [DATA_W:0]       sum9;
    logic [2*DATA_W-1:0]   sh_tmp;

    always_comb begin
        sum9    = '0;
        sh_tmp  = '0;
        result  = '0;
        cout    = 1'b0;
        c_valid = 1'b0;
        if (is_shift) begin
            // Double-width staging: the bit adjacent to the kept byte is the last bit shifted out.
            case (scode)
                SCODE_SHL: begin
                    sh_tmp = {8'h00, a} << shamt;
                    result = sh_tmp[7:0];
                    cout   = sh_tmp[8];
                end
                SCODE_SHR: begin
                    sh_tmp = {a, 8'h00} >> shamt;
                    result = sh_tmp[15:8];
                    cout   = sh_tmp[7];
                end
                SCODE_ROL: begin
                    sh_tmp = {a, a} << shamt;
                    result = sh_tmp[15:8];
                    cout   = sh_tmp[8];
                end
                default: begin
                    sh_tmp = {a, a} >> shamt;
                    result = sh_tmp[7:0];
                    cout   = sh_tmp[7];
                end
            endcase
            c_valid = (shamt != 3'd0);
        end else begin
            case (acode)
                ACODE_ADD: sum9 = {1'b0, a} + {1'b0, b};
                ACODE_ADC: sum9 = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                ACODE_SUB: sum9 = {1'b0, a} - {1'b0, b};
                ACODE_SBC: sum9 = {1'b0, a} - {1'b0, b} - {8'h00, cin};
                default:   sum9 = '0;
            endcase
            case (acode)
                ACODE_AND:   result = a & b;
                ACODE_OR:    result = a | b;
                ACODE_XOR:   result = a ^ b;
                ACODE_PASSB: result = b;
                default: begin
                    // For subtraction the 9th bit of the difference is the borrow.
                    result  = sum9[7:0];
                    cout    = sum9[8];
                    c_valid = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU/shifter, Z/C flags, branch target and the EX/MEM latch.
module ex_stage
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_new_pc,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_ins70,
    input  logic [REG_W-1:0]  in_ins1311,
    input  logic              in_EX_is_shift,
    input  logic              in_EX_alu_src,
    input  logic              in_EX_update_z_c,
    input  logic [1:0]        in_EX_scode,
    input  logic [2:0]        in_EX_acode,
    input  logic              in_MEM_mem_read_write,
    input  logic [1:0]        in_MEM_pc_src,
    input  logic              in_WB_mem_or_alu,
    input  logic              in_WB_reg_write_signal,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dest,
    output logic [PC_W-1:0]   out_branch_target,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_MEM_mem_read_write,
    output logic [1:0]        out_MEM_pc_src,
    output logic              out_WB_mem_or_alu,
    output logic              out_WB_reg_write_signal
);

    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              alu_c_valid;
    logic [PC_W-1:0]   branch_target;
    logic              flag_we;
    logic              z_q;
    logic              c_q;
    exmem_t            exmem_d;
    exmem_t            exmem_q;

    assign operand_b     = in_EX_alu_src ? in_ins70 : in_data_2;
    assign branch_target = in_new_pc + sext_offset(in_ins70);
    assign flag_we       = in_valid & in_EX_update_z_c & ~stall & ~flush;

    alu8 u_alu8 (
        .a        (in_data_1),
        .b        (operand_b),
        .cin      (c_q),
        .acode    (in_EX_acode),
        .is_shift (in_EX_is_shift),
        .scode    (in_EX_scode),
        .shamt    (in_ins70[2:0]),
        .result   (alu_result),
        .cout     (alu_cout),
        .c_valid  (alu_c_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else if (flag_we) begin
            z_q <= (alu_result == '0);
            if (alu_c_valid) begin
                c_q <= alu_cout;
            end
        end
    end

    always_comb begin
        exmem_d = EXMEM_BUBBLE;
        if (in_valid) begin
            exmem_d.valid          = 1'b1;
            exmem_d.result         = alu_result;
            exmem_d.store_data     = in_data_2;
            exmem_d.dest           = in_ins1311;
            exmem_d.branch_target  = branch_target;
            exmem_d.mem_read_write = in_MEM_mem_read_write;
            exmem_d.pc_src         = in_MEM_pc_src;
            exmem_d.mem_or_alu     = in_WB_mem_or_alu;
            exmem_d.reg_write      = in_WB_reg_write_signal;
        end
    end

    // Flush wins over stall so the hazard unit can kill a held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= EXMEM_BUBBLE;
        end else if (flush) begin
            exmem_q <= EXMEM_BUBBLE;
        end else if (!stall) begin
            exmem_q <= exmem_d;
        end
    end

    assign out_valid               = exmem_q.valid;
    assign out_result              = exmem_q.result;
    assign out_store_data          = exmem_q.store_data;
    assign out_dest                = exmem_q.dest;
    assign out_branch_target       = exmem_q.branch_target;
    assign out_MEM_mem_read_write  = exmem_q.mem_read_write;
    assign out_MEM_pc_src          = exmem_q.pc_src;
    assign out_WB_mem_or_alu       = exmem_q.mem_or_alu;
    assign out_WB_reg_write_signal = exmem_q.reg_write;
    assign out_zero                = z_q;
    assign out_carry               = c_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, flush, in_valid;
    logic [11:0] in_new_pc;
    logic [7:0]  in_data_1, in_data_2, in_ins70;
    logic [2:0]  in_ins1311;
    logic        in_EX_is_shift, in_EX_alu_src, in_EX_update_z_c;
    logic [1:0]  in_EX_scode;
    logic [2:0]  in_EX_acode;
    logic        in_MEM_mem_read_write;
    logic [1:0]  in_MEM_pc_src;
    logic        in_WB_mem_or_alu, in_WB_reg_write_signal;

    logic        out_valid;
    logic [7:0]  out_result, out_store_data;
    logic [2:0]  out_dest;
    logic [11:0] out_branch_target;
    logic        out_zero, out_carry;
    logic        out_MEM_mem_read_write;
    logic [1:0]  out_MEM_pc_src;
    logic        out_WB_mem_or_alu, out_WB_reg_write_signal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_new_pc(in_new_pc), .in_data_1(in_data_1), .in_data_2(in_data_2),
        .in_ins70(in_ins70), .in_ins1311(in_ins1311),
        .in_EX_is_shift(in_EX_is_shift), .in_EX_alu_src(in_EX_alu_src),
        .in_EX_update_z_c(in_EX_update_z_c), .in_EX_scode(in_EX_scode),
        .in_EX_acode(in_EX_acode), .in_MEM_mem_read_write(in_MEM_mem_read_write),
        .in_MEM_pc_src(in_MEM_pc_src), .in_WB_mem_or_alu(in_WB_mem_or_alu),
        .in_WB_reg_write_signal(in_WB_reg_write_signal),
        .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
        .out_dest(out_dest), .out_branch_target(out_branch_target),
        .out_zero(out_zero), .out_carry(out_carry),
        .out_MEM_mem_read_write(out_MEM_mem_read_write), .out_MEM_pc_src(out_MEM_pc_src),
        .out_WB_mem_or_alu(out_WB_mem_or_alu), .out_WB_reg_write_signal(out_WB_reg_write_signal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: operations evaluated as integer arithmetic and bit-by-bit shifting.
    task automatic ref_op(input int a, input int b, input int cin, input int ac,
                          input bit sh, input int sc, input int amt,
                          output int r, output bit cvalid, output bit cout);
        int s;
        logic [7:0] v;
        cvalid = 1'b0;
        cout   = 1'b0;
        if (sh) begin
            v = a[7:0];
            for (int i = 0; i < amt; i++) begin
                case (sc)
                    0: begin cout = v[7]; v = {v[6:0], 1'b0}; end
                    1: begin cout = v[0]; v = {1'b0, v[7:1]}; end
                    2: begin cout = v[7]; v = {v[6:0], v[7]}; end
                    default: begin cout = v[0]; v = {v[0], v[7:1]}; end
                endcase
                cvalid = 1'b1;
            end
            r = int'(v);
        end else begin
            case (ac)
                0: begin s = a + b;       cout = (s > 255);    cvalid = 1'b1; end
                1: begin s = a + b + cin; cout = (s > 255);    cvalid = 1'b1; end
                2: begin s = a - b;       cout = (a < b);       cvalid = 1'b1; end
                3: begin s = a - b - cin; cout = (a < b + cin); cvalid = 1'b1; end
                4: s = a & b;
                5: s = a | b;
                6: s = a ^ b;
                default: s = b;
            endcase
            r = s & 255;
        end
    endtask

    int m_valid, m_result, m_store, m_dest, m_bt, m_z, m_c, m_mrw, m_pcsrc, m_moa, m_rw;

    task automatic model_bubble();
        m_valid = 0; m_result = 0; m_store = 0; m_dest = 0; m_bt = 0;
        m_mrw = 0; m_pcsrc = 0; m_moa = 0; m_rw = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        int r, off, bop;
        bit cv, co;
        if (!rst_n) begin
            model_bubble();
            m_z = 0;
            m_c = 0;
        end else if (flush) begin
            model_bubble();
        end else if (!stall) begin
            if (in_valid) begin
                bop = in_EX_alu_src ? int'(in_ins70) : int'(in_data_2);
                ref_op(int'(in_data_1), bop, m_c, int'(in_EX_acode), in_EX_is_shift,
                       int'(in_EX_scode), int'(in_ins70[2:0]), r, cv, co);
                off = (in_ins70 >= 8'd128) ? int'(in_ins70) - 256 : int'(in_ins70);
                m_valid = 1; m_result = r; m_store = int'(in_data_2); m_dest = int'(in_ins1311);
                m_bt = (int'(in_new_pc) + off + 4096) % 4096;
                m_mrw = int'(in_MEM_mem_read_write); m_pcsrc = int'(in_MEM_pc_src);
                m_moa = int'(in_WB_mem_or_alu); m_rw = int'(in_WB_reg_write_signal);
                if (in_EX_update_z_c) begin
                    m_z = (r == 0) ? 1 : 0;
                    if (cv) m_c = co ? 1 : 0;
                end
            end else begin
                model_bubble();
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("m_valid",  32'(out_valid),               32'(m_valid));
            chk("m_result", 32'(out_result),              32'(m_result));
            chk("m_store",  32'(out_store_data),          32'(m_store));
            chk("m_dest",   32'(out_dest),                32'(m_dest));
            chk("m_btgt",   32'(out_branch_target),       32'(m_bt));
            chk("m_zero",   32'(out_zero),                32'(m_z));
            chk("m_carry",  32'(out_carry),               32'(m_c));
            chk("m_mrw",    32'(out_MEM_mem_read_write),  32'(m_mrw));
            chk("m_pcsrc",  32'(out_MEM_pc_src),          32'(m_pcsrc));
            chk("m_moa",    32'(out_WB_mem_or_alu),       32'(m_moa));
            chk("m_rw",     32'(out_WB_reg_write_signal), 32'(m_rw));
        end
    end

    task automatic idle();
        stall = 0; flush = 0; in_valid = 0; in_new_pc = 0; in_data_1 = 0; in_data_2 = 0;
        in_ins70 = 0; in_ins1311 = 0; in_EX_is_shift = 0; in_EX_alu_src = 0;
        in_EX_update_z_c = 0; in_EX_scode = 0; in_EX_acode = 0; in_MEM_mem_read_write = 0;
        in_MEM_pc_src = 0; in_WB_mem_or_alu = 0; in_WB_reg_write_signal = 0;
    endtask

    task automatic op(input logic [2:0] ac, input logic sh, input logic [1:0] sc,
                      input logic [7:0] d1, input logic [7:0] d2, input logic src,
                      input logic [7:0] imm);
        in_valid = 1; in_EX_update_z_c = 1; in_EX_acode = ac; in_EX_is_shift = sh;
        in_EX_scode = sc; in_data_1 = d1; in_data_2 = d2; in_EX_alu_src = src; in_ins70 = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic chk_res(input string name, input logic [7:0] r, input logic z, input logic c);
        chk({name, "_res"}, 32'(out_result), 32'(r));
        chk({name, "_z"},   32'(out_zero),   32'(z));
        chk({name, "_c"},   32'(out_carry),  32'(c));
    endtask

    initial begin
        idle();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
        #22 rst_n = 1;
        #5;

        op(3'd0, 0, 2'd0, 8'hF0, 8'h20, 0, 8'h00);
        in_ins1311 = 3'd5; in_WB_reg_write_signal = 1; in_MEM_pc_src = 2'd2;
        step();
        chk_res("add", 8'h10, 0, 1);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_store", 32'(out_store_data), 32'h20);
        chk("add_dest", 32'(out_dest), 32'd5);
        chk("add_pcsrc", 32'(out_MEM_pc_src), 32'd2);

        op(3'd1, 0, 2'd0, 8'h01, 8'h01, 0, 8'h00);
        step();
        chk_res("adc", 8'h03, 0, 0);

        op(3'd2, 0, 2'd0, 8'h05, 8'h99, 1, 8'h05);
        step();
        chk_res("subi0", 8'h00, 1, 0);
        op(3'd2, 0, 2'd0, 8'h03, 8'h99, 1, 8'h05);
        step();
        chk_res("subi1", 8'hFE, 0, 1);

        op(3'd0, 1, 2'd0, 8'h81, 8'h00, 0, 8'h01);
        step();
        chk_res("shl", 8'h02, 0, 1);
        op(3'd0, 1, 2'd3, 8'h81, 8'h00, 0, 8'h01);
        step();
        chk_res("ror", 8'hC0, 0, 1);
        op(3'd0, 1, 2'd0, 8'h81, 8'h00, 0, 8'h00);
        step();
        chk_res("sh0", 8'h81, 0, 1);

        op(3'd2, 0, 2'd0, 8'h01, 8'h01, 0, 8'h00);
        stall = 1;
        step();
        chk_res("stall1", 8'h81, 0, 1);
        chk("stall1_valid", 32'(out_valid), 32'd1);
        step();
        chk_res("stall2", 8'h81, 0, 1);
        chk("stall2_rw", 32'(out_WB_reg_write_signal), 32'd1);
        flush = 1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_rw", 32'(out_WB_reg_write_signal), 32'd0);
        chk("flush_pcsrc", 32'(out_MEM_pc_src), 32'd0);
        chk("flush_z", 32'(out_zero), 32'd0);
        chk("flush_c", 32'(out_carry), 32'd1);
        stall = 0; flush = 0;

        in_EX_update_z_c = 0;
        in_new_pc = 12'h010; in_ins70 = 8'hFC;
        step();
        chk("bt_neg", 32'(out_branch_target), 32'h00C);
        in_new_pc = 12'hFFF; in_ins70 = 8'h01;
        step();
        chk("bt_wrap", 32'(out_branch_target), 32'h000);
        in_new_pc = 12'h100; in_ins70 = 8'h80;
        step();
        chk("bt_m128", 32'(out_branch_target), 32'h080);

        op(3'd7, 0, 2'd0, 8'h00, 8'h55, 0, 8'h00);
        step();
        chk("pre_rst_res", 32'(out_result), 32'h55);
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_res", 32'(out_result), 32'd0);
        chk("arst_rw", 32'(out_WB_reg_write_signal), 32'd0);
        chk("arst_c", 32'(out_carry), 32'd0);
        #2 rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in_new_pc = 12'($urandom);
            in_data_1 = 8'($urandom);
            in_data_2 = 8'($urandom);
            in_ins70 = 8'($urandom);
            in_ins1311 = 3'($urandom);
            in_EX_is_shift = 1'($urandom);
            in_EX_alu_src = 1'($urandom);
            in_EX_update_z_c = ($urandom_range(0, 3) != 0);
            in_EX_scode = 2'($urandom);
            in_EX_acode = 3'($urandom);
            in_MEM_mem_read_write = 1'($urandom);
            in_MEM_pc_src = 2'($urandom);
            in_WB_mem_or_alu = 1'($urandom);
            in_WB_reg_write_signal = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
